// File: rtl/cpu_cfg_regfile.sv
// CPU-bus slave holding the per-VPI cell configuration table ({FWD, VPI} per entry).
// Intel/Motorola handshake with programmable wait states, plus a registered datapath lookup port.
module cpu_cfg_regfile #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned VPI_W       = 12,
    parameter int unsigned DATA_W      = NUM_PORTS + VPI_W,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     BusMode,
    input  logic [ADDR_W-1:0]        Addr,
    input  logic                     Sel,
    input  logic [DATA_W-1:0]        DataIn,
    input  logic                     Rd_DS,
    input  logic                     Wr_RW,
    output logic [DATA_W-1:0]        DataOut,
    output logic                     Rdy_Dtack,
    output logic                     err_addr,
    input  logic [$clog2(DEPTH)-1:0] lkup_addr,
    output logic [DATA_W-1:0]        lkup_data
);

    localparam int unsigned IdxW     = $clog2(DEPTH);
    localparam logic [3:0]  WaitLast = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAck, StRelease} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   dout_q, lkup_q;
    logic                rdy_q, err_q;

    logic                start, strobe, active, go_ack;
    logic                acc_wr;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_data, rd_val;
    logic [IdxW-1:0]     acc_idx;
    logic                in_range, wr_en;

    assign start  = !Sel && (BusMode ? (Rd_DS != Wr_RW) : !Rd_DS);
    assign strobe = mode_q ? (wr_q ? Wr_RW : Rd_DS) : Rd_DS;
    assign active = !Sel && !strobe;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        go_ack   = 1'b0;
        acc_wr   = wr_q;
        acc_addr = addr_q;
        acc_data = data_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d   = BusMode;
                    wr_d     = !Wr_RW;
                    addr_d   = Addr;
                    data_d   = DataIn;
                    cnt_d    = '0;
                    // With no wait states the access commits on the start edge itself.
                    acc_wr   = !Wr_RW;
                    acc_addr = Addr;
                    acc_data = DataIn;
                    if (WAIT_STATES == 0) begin
                        state_d = StAck;
                        go_ack  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!active) begin
                    state_d = StIdle;
                end else if (cnt_q >= WaitLast) begin
                    state_d = StAck;
                    go_ack  = 1'b1;
                end else if (cnt_q != 4'hF) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StAck: begin
                if (!active) begin
                    state_d = StRelease;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    assign acc_idx  = acc_addr[IdxW-1:0];
    assign in_range = (acc_addr >> IdxW) == '0;
    assign wr_en    = go_ack && acc_wr && in_range;
    assign rd_val   = (!acc_wr && in_range) ? mem_q[acc_idx] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[acc_idx] <= acc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
            lkup_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            // Acknowledge trails the ACK state by one cycle, so DataOut is settled before it.
            rdy_q   <= (state_q != StAck);
            lkup_q  <= mem_q[lkup_addr];
            if (go_ack) begin
                dout_q <= rd_val;
                err_q  <= !in_range;
            end else begin
                err_q <= 1'b0;
                if (state_d != StAck) begin
                    dout_q <= '0;
                end
            end
        end
    end

    assign DataOut   = dout_q;
    assign Rdy_Dtack = rdy_q;
    assign err_addr  = err_q;
    assign lkup_data = lkup_q;

endmodule

// File: tb/tb_cpu_cfg_regfile.sv
// Bench for cpu_cfg_regfile: three instances with 0, 1 and 3 wait states share the bus,
// one selected at a time through its chip select.
module tb_cpu_cfg_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [11:0] addr;
    logic        sel;
    logic [15:0] data_in;
    logic        rd_ds;
    logic        wr_rw;
    logic [7:0]  lkup_addr;
    int          dut_id;

    logic        sel0, sel1, sel2;
    logic [15:0] dout0, dout1, dout2, lk0, lk1, lk2;
    logic        rdy0, rdy1, rdy2, err0, err1, err2;
    logic [15:0] dout, lk;
    logic        rdy, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign sel0 = (dut_id == 0) ? sel : 1'b1;
    assign sel1 = (dut_id == 1) ? sel : 1'b1;
    assign sel2 = (dut_id == 2) ? sel : 1'b1;
    assign dout = (dut_id == 0) ? dout0 : (dut_id == 1) ? dout1 : dout2;
    assign rdy  = (dut_id == 0) ? rdy0  : (dut_id == 1) ? rdy1  : rdy2;
    assign err  = (dut_id == 0) ? err0  : (dut_id == 1) ? err1  : err2;
    assign lk   = (dut_id == 0) ? lk0   : (dut_id == 1) ? lk1   : lk2;

    cpu_cfg_regfile #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .BusMode(mode), .Addr(addr), .Sel(sel0), .DataIn(data_in),
        .Rd_DS(rd_ds), .Wr_RW(wr_rw), .DataOut(dout0), .Rdy_Dtack(rdy0), .err_addr(err0),
        .lkup_addr(lkup_addr), .lkup_data(lk0)
    );
    cpu_cfg_regfile #(.WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .BusMode(mode), .Addr(addr), .Sel(sel1), .DataIn(data_in),
        .Rd_DS(rd_ds), .Wr_RW(wr_rw), .DataOut(dout1), .Rdy_Dtack(rdy1), .err_addr(err1),
        .lkup_addr(lkup_addr), .lkup_data(lk1)
    );
    cpu_cfg_regfile #(.WAIT_STATES(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .BusMode(mode), .Addr(addr), .Sel(sel2), .DataIn(data_in),
        .Rd_DS(rd_ds), .Wr_RW(wr_rw), .DataOut(dout2), .Rdy_Dtack(rdy2), .err_addr(err2),
        .lkup_addr(lkup_addr), .lkup_data(lk2)
    );

    typedef struct {
        int          d;
        bit          mot;
        bit          wr;
        logic [11:0] a;
        logic [15:0] din;
        logic [15:0] exp_rd;
        int          exp_lat;
        int          exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        sel   = 1'b1;
        rd_ds = 1'b1;
        wr_rw = 1'b1;
    endtask

    task automatic drive_start(input bit mot, input bit wr);
        mode = ~mot;
        sel  = 1'b0;
        if (mot) begin
            rd_ds = 1'b0;
            wr_rw = !wr;
        end else begin
            rd_ds = wr;
            wr_rw = !wr;
        end
    endtask

    // Full access: checks latency, read data, hold in ACK, release and err_addr pulse count.
    task automatic cpu_access(input string tag, input vec_t v);
        logic [15:0] rdata = '0;
        int          lat   = 0;
        int          errs  = 0;
        dut_id  = v.d;
        addr    = v.a;
        data_in = v.din;
        drive_start(v.mot, v.wr);
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (err) errs++;
            if (c == 1) begin
                addr    = ~v.a;
                data_in = ~v.din;
            end
            if (!rdy) begin
                lat   = c;
                rdata = dout;
                break;
            end
        end
        check({tag, " ack latency"}, lat, v.exp_lat);
        check({tag, " read data"}, rdata, v.exp_rd);
        tick();
        if (err) errs++;
        check({tag, " ack held"}, rdy, 1'b0);
        check({tag, " data held"}, dout, v.exp_rd);
        bus_idle();
        tick();
        if (err) errs++;
        tick();
        if (err) errs++;
        check({tag, " ack released"}, rdy, 1'b1);
        check({tag, " data cleared"}, dout, 16'h0);
        check({tag, " err pulses"}, errs, v.exp_err);
    endtask

    initial begin
        bool_init();
    end

    task automatic bool_init();
        int seen;
        rst_n     = 1'b0;
        mode      = 1'b1;
        addr      = '0;
        data_in   = '0;
        lkup_addr = '0;
        dut_id    = 0;
        bus_idle();

        vecs[0]  = '{1, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h0000, 3, 0};
        vecs[1]  = '{1, 1'b0, 1'b0, 12'h005, 16'h0000, 16'h0000, 3, 0};
        vecs[2]  = '{1, 1'b0, 1'b0, 12'h0FF, 16'h0000, 16'h0000, 3, 0};
        vecs[3]  = '{1, 1'b0, 1'b1, 12'h012, 16'hA3AB, 16'h0000, 3, 0};
        vecs[4]  = '{1, 1'b0, 1'b0, 12'h012, 16'h0000, 16'hA3AB, 3, 0};
        vecs[5]  = '{0, 1'b1, 1'b1, 12'h0FF, 16'h5001, 16'h0000, 2, 0};
        vecs[6]  = '{0, 1'b1, 1'b0, 12'h0FF, 16'h0000, 16'h5001, 2, 0};
        vecs[7]  = '{1, 1'b0, 1'b1, 12'h100, 16'hFFFF, 16'h0000, 3, 1};
        vecs[8]  = '{1, 1'b0, 1'b0, 12'h100, 16'h0000, 16'h0000, 3, 1};
        vecs[9]  = '{1, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h0000, 3, 0};
        vecs[10] = '{1, 1'b1, 1'b1, 12'h0FF, 16'h1111, 16'h0000, 3, 0};
        vecs[11] = '{1, 1'b0, 1'b0, 12'h0FF, 16'h0000, 16'h1111, 3, 0};
        vecs[12] = '{0, 1'b0, 1'b0, 12'h0FF, 16'h0000, 16'h5001, 2, 0};
        vecs[13] = '{2, 1'b1, 1'b1, 12'h020, 16'h00C3, 16'h0000, 5, 0};

        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            dut_id = d;
            #1;
            check($sformatf("reset rdy dut%0d", d), rdy, 1'b1);
            check($sformatf("reset dout dut%0d", d), dout, 16'h0);
            check($sformatf("reset err dut%0d", d), err, 1'b0);
            check($sformatf("reset lkup dut%0d", d), lk, 16'h0);
        end
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            cpu_access($sformatf("vec%0d", i), vecs[i]);
            if (i == 4) begin
                lkup_addr = 8'h12;
                tick();
                check("lookup 0x12", lk, 16'hA3AB);
            end
        end

        // Abort: Sel released during WAIT (3 wait states), nothing written or acknowledged.
        dut_id  = 2;
        addr    = 12'h007;
        data_in = 16'hBEEF;
        drive_start(1'b0, 1'b1);
        tick();
        bus_idle();
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (!rdy) seen++;
        end
        check("abort no ack", seen, 0);
        cpu_access("abort readback", '{2, 1'b0, 1'b0, 12'h007, 16'h0, 16'h0000, 5, 0});

        // Collision: write of entry 9 and lookup of entry 9 on the same edge.
        dut_id    = 1;
        lkup_addr = 8'd9;
        addr      = 12'h009;
        data_in   = 16'h1234;
        drive_start(1'b0, 1'b1);
        tick();
        check("collision before commit", lk, 16'h0000);
        tick();
        check("collision same edge old", lk, 16'h0000);
        tick();
        check("collision next cycle new", lk, 16'h1234);
        check("collision ack", rdy, 1'b0);
        bus_idle();
        tick();
        tick();
        check("collision release", rdy, 1'b1);

        // Reset asserted while a write to entry 9 sits in WAIT.
        addr    = 12'h009;
        data_in = 16'h4321;
        drive_start(1'b0, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        check("reset mid-wait rdy", rdy, 1'b1);
        tick();
        check("reset mid-wait rdy held", rdy, 1'b1);
        bus_idle();
        rst_n = 1'b1;
        tick();
        check("post reset lookup 9", lk, 16'h0000);
        cpu_access("post reset read 9", '{1, 1'b0, 1'b0, 12'h009, 16'h0, 16'h0000, 3, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

endmodule

// File: doc/cpu_cfg_regfile.md
# cpu_cfg_regfile

Parametrised CPU-bus slave holding the per-VPI cell configuration table (forward mask + new VPI) for the ATM switch. It accepts accesses from the CPU bus in Intel or Motorola mode with programmable wait states. It also provides a registered lookup port for the cell datapath. It generalises the fixed-width CPU peripheral to N switch ports, configurable depth, and a dual-mode handshake FSM with abort and out-of-range handling.

## Interface

- NUM_PORTS, 4: switch port count; width of the forward mask FWD.
- VPI_W, 12: width of the VPI field.
- DATA_W, NUM_PORTS+VPI_W: entry width, packed as {FWD, VPI}.
- ADDR_W, 12: CPU address width.
- DEPTH, 256: number of table entries, power of two, DEPTH ≤ 2^ADDR_W.
- WAIT_STATES, 1: extra cycles inserted before acknowledge, 0..15.
- clk  in  1  single clock; every input is sampled on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- BusMode  in  1  1 = Intel (Rd/Wr strobes, Rdy); 0 = Motorola (DS, R/W, Dtack).
- Addr  in  ADDR_W  entry address.
- Sel  in  1  chip select, active-low.
- DataIn  in  DATA_W  write data from the CPU.
- Rd_DS  in  1  Intel: read strobe, active-low; Motorola: data strobe, active-low.
- Wr_RW  in  1  Intel: write strobe, active-low; Motorola: 1 = read, 0 = write.
- DataOut  out  DATA_W  read data to the CPU.
- Rdy_Dtack  out  1  acknowledge, active-low.
- err_addr  out  1  one-cycle pulse on an acknowledged out-of-range access.
- lkup_addr  in  $clog2(DEPTH)  datapath lookup index (VPI).
- lkup_data  out  DATA_W  registered lookup result.

## Operation

- Start condition, evaluated only in IDLE:
  - Intel: Sel=0 and exactly one of Rd_DS / Wr_RW low. Rd_DS low = read; Wr_RW low = write. Both low is ignored and the FSM stays in IDLE.
  - Motorola: Sel=0 and Rd_DS=0. Wr_RW selects the direction (1 = read, 0 = write).
- At start, the FSM latches BusMode, direction, Addr and DataIn. Later changes to these inputs during the access have no effect.
- FSM states:
  - IDLE → WAIT on start if WAIT_STATES > 0; otherwise IDLE → ACK.
  - WAIT: counter counts WAIT_STATES cycles, then → ACK.
  - ACK: Rdy_Dtack=0. Stays in ACK while the access is still active (Sel=0 and the latched-mode strobe low). → RELEASE when the access goes inactive.
  - RELEASE: Rdy_Dtack=1, DataOut=0, unconditionally → IDLE. This guarantees one idle cycle between accesses.
- Abort: if Sel or the strobe deasserts during WAIT, the FSM goes to IDLE. No write is performed and no acknowledge is given.
- Write: the table entry is updated on the clock edge that enters ACK.
- Read: DataOut is loaded on the edge that enters ACK and held through ACK. Outside ACK, DataOut=0.
- Out-of-range access (Addr ≥ DEPTH): writes are dropped; reads return 0. The access is still acknowledged, and err_addr is high for the first ACK cycle only.
- Lookup port: lkup_data is the registered table entry at lkup_addr, available every cycle with 1-cycle latency.
  - If a CPU write hits the same entry on the same edge, lkup_data returns the old value. The new value is visible on the next lookup.

## Timing

- Reset (rst_n=0 at an edge):
  - FSM → IDLE and the wait counter clears.
  - Outputs: Rdy_Dtack=1, DataOut=0, err_addr=0, lkup_data=0.
  - All table entries clear to 0 (FWD=0 means drop).
- Reset mid-access aborts the access; a write not yet committed is lost.
- Acknowledge latency: with start sampled at edge N, Rdy_Dtack goes low after edge N+1+WAIT_STATES.
- Rdy_Dtack returns high one cycle after the access goes inactive.
- Minimum access: 3+WAIT_STATES cycles from start through RELEASE.
- Back-to-back: a new start is recognised in IDLE, earliest the edge after RELEASE.
- The wait counter is 4 bits and saturates. It does not wrap.

## Test plan

- Reset: drive rst_n=0 for 2 cycles → Rdy_Dtack=1, DataOut=0, err_addr=0, lkup_data=0. Reading entries 0, 5 and 255 returns 0.
- Intel write then read, WAIT_STATES=1:
  - Write Addr=0x012 with DataIn={4'b1010,12'h3AB} → Rdy low at N+2.
  - Read back the same address → DataOut=0xA3AB while Rdy is low.
  - lkup_addr=0x12 → lkup_data=0xA3AB one cycle later.
- Motorola mode, WAIT_STATES=0:
  - Write (DS=0, RW=0) Addr=0x0FF with data 0x5001 → Dtack low at N+1.
  - Read (RW=1) → 0x5001. Dtack stays low until DS rises, then goes high one cycle later.
- Abort: with WAIT_STATES=3, start an Intel write to Addr 7 and raise Sel after 1 cycle → Rdy never goes low and entry 7 is unchanged (0).
- Out of range: write 0xFFFF to Addr=0x100 with DEPTH=256 → acknowledged, err_addr pulses for one cycle, no entry changes. A read of 0x100 returns 0 and err_addr pulses again.
- Collision and reset: CPU write of 0x1234 to entry 9 and lkup_addr=9 on the same edge → lkup_data shows the old value, then 0x1234 the next cycle. Asserting rst_n=0 during the WAIT of a later write to entry 9 → Rdy stays high and entry 9 reads 0 after reset.
